// File: rtl/exu_muldiv.sv
// Iterative RV64M multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Define YSYX_23060251_MUL_FAST_EN to replace the iterative multiply with a single-cycle product.
//
// state  | meaning
// S_IDLE | waiting for an operation, in_ready_o high
// S_MUL  | shift-add multiply, one multiplier bit per cycle
// S_DIV  | restoring divide, one quotient bit per cycle
// S_DONE | result held on result_o until out_ready_i
module exu_muldiv #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [7:0]      op_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o,
    output logic [4:0]      busy_rd_o
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_opnd;
    logic [CW-1:0]       r_cnt;
    logic                r_neg, r_sel_lo, r_sel_rem;
    logic [4:0]          r_rd;
    logic [XLEN-1:0]     r_result;

    logic                w_accept, w_op_mul, w_op_div, w_div0, w_ovf, w_div_special;
    logic                w_s1_neg, w_s2_neg, w_neg_in, w_last, w_ge;
    logic [XLEN-1:0]     w_mag1, w_mag2, w_special_res;
    logic [XLEN:0]       w_mul_sum, w_rem_sh;
    logic [XLEN+1:0]     w_diff;
    logic [XLEN-1:0]     w_rem_new, w_quo_rem, w_div_res, w_fin;
    logic [2*XLEN-1:0]   w_mul_next, w_div_next, w_step_next, w_prod_sgn;

    // op_i one-hot: [0]mul [1]mulh [2]mulhsu [3]mulhu [4]div [5]divu [6]rem [7]remu
    assign w_op_mul = |op_i[3:0];
    assign w_op_div = |op_i[7:4];
    assign w_accept = in_valid_i & (r_state == S_IDLE) & (|op_i) & ~flush_i;

    assign w_s1_neg = (op_i[1] | op_i[2] | op_i[4] | op_i[6]) & src1_i[XLEN-1];
    assign w_s2_neg = (op_i[1] | op_i[4] | op_i[6]) & src2_i[XLEN-1];
    assign w_mag1   = w_s1_neg ? -src1_i : src1_i;
    assign w_mag2   = w_s2_neg ? -src2_i : src2_i;
    assign w_neg_in = (op_i[6] | op_i[7]) ? w_s1_neg : (w_s1_neg ^ w_s2_neg);

    assign w_div0        = w_op_div & (src2_i == '0);
    assign w_ovf         = (op_i[4] | op_i[6]) & (src1_i == {1'b1, {(XLEN-1){1'b0}}}) & (&src2_i);
    assign w_div_special = w_div0 | w_ovf;
    assign w_special_res = w_div0 ? ((op_i[4] | op_i[5]) ? '1 : src1_i)
                                  : (op_i[4] ? src1_i : '0);

    // Multiply: accumulate into the upper half, shift the multiplier out of the lower half.
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // Divide: remainder in the upper half, dividend shifts in and quotient bits fill the lower half.
    assign w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
    assign w_diff     = {1'b0, w_rem_sh} - {2'b0, r_opnd};
    assign w_ge       = ~w_diff[XLEN+1];
    assign w_rem_new  = w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
    assign w_div_next = {w_rem_new, r_acc[XLEN-2:0], w_ge};

    assign w_step_next = (r_state == S_MUL) ? w_mul_next : w_div_next;
    assign w_last      = (r_cnt == CW'(XLEN-1));

    assign w_prod_sgn = r_neg ? -w_step_next : w_step_next;
    assign w_quo_rem  = r_sel_rem ? w_step_next[2*XLEN-1:XLEN] : w_step_next[XLEN-1:0];
    assign w_div_res  = r_neg ? -w_quo_rem : w_quo_rem;
    assign w_fin      = (r_state == S_MUL)
                        ? (r_sel_lo ? w_prod_sgn[XLEN-1:0] : w_prod_sgn[2*XLEN-1:XLEN])
                        : w_div_res;

`ifdef YSYX_23060251_MUL_FAST_EN
    logic [2*XLEN-1:0] w_fast_prod, w_fast_sgn;
    logic [XLEN-1:0]   w_fast_res;
    assign w_fast_prod = {{XLEN{1'b0}}, w_mag1} * {{XLEN{1'b0}}, w_mag2};
    assign w_fast_sgn  = w_neg_in ? -w_fast_prod : w_fast_prod;
    assign w_fast_res  = op_i[0] ? w_fast_sgn[XLEN-1:0] : w_fast_sgn[2*XLEN-1:XLEN];
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_op_mul) begin
`ifdef YSYX_23060251_MUL_FAST_EN
                        w_state_nxt = S_DONE;
`else
                        w_state_nxt = S_MUL;
`endif
                    end else if (w_div_special) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_DIV;
                    end
                end
            end
            S_MUL, S_DIV: if (w_last) w_state_nxt = S_DONE;
            S_DONE:       if (out_ready_i) w_state_nxt = S_IDLE;
            default:      w_state_nxt = S_IDLE;
        endcase
        if (flush_i) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_opnd    <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_sel_lo  <= 1'b0;
            r_sel_rem <= 1'b0;
            r_rd      <= '0;
            r_result  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_rd      <= rd_i;
                r_cnt     <= '0;
                r_neg     <= w_neg_in;
                r_sel_lo  <= op_i[0];
                r_sel_rem <= op_i[6] | op_i[7];
                r_opnd    <= w_op_mul ? w_mag1 : w_mag2;
                r_acc     <= {{XLEN{1'b0}}, (w_op_mul ? w_mag2 : w_mag1)};
                if (w_op_div && w_div_special) r_result <= w_special_res;
`ifdef YSYX_23060251_MUL_FAST_EN
                if (w_op_mul) r_result <= w_fast_res;
`endif
            end else if ((r_state == S_MUL || r_state == S_DIV) && !flush_i) begin
                r_acc <= w_step_next;
                r_cnt <= r_cnt + 1'b1;
                if (w_last) r_result <= w_fin;
            end
        end
    end

    // A flush in DONE suppresses the handoff in the same cycle.
    assign in_ready_o  = (r_state == S_IDLE);
    assign out_valid_o = (r_state == S_DONE) & ~flush_i;
    assign result_o    = r_result;
    assign rd_o        = r_rd;
    assign busy_rd_o   = (r_state == S_IDLE) ? 5'd0 : r_rd;

endmodule

// File: tb/tb_exu_muldiv.sv
// Randomized bench for exu_muldiv against an arithmetic reference model,
// plus directed corner cases: special divides, output hold, flush and mid-operation reset.
module tb_exu_muldiv;

    localparam logic [7:0] OP_MUL = 8'h01, OP_MULH = 8'h02, OP_MULHSU = 8'h04, OP_MULHU = 8'h08;
    localparam logic [7:0] OP_DIV = 8'h10, OP_DIVU = 8'h20, OP_REM = 8'h40, OP_REMU = 8'h80;
    localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [7:0]  op_i = '0;
    logic [63:0] src1_i = '0;
    logic [63:0] src2_i = '0;
    logic [4:0]  rd_i = '0;
    logic        flush_i = 1'b0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [63:0] result_o;
    logic [4:0]  rd_o;
    logic [4:0]  busy_rd_o;

    int n_checks = 0;
    int n_fail   = 0;

    exu_muldiv #(.XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .op_i(op_i), .src1_i(src1_i), .src2_i(src2_i), .rd_i(rd_i),
        .flush_i(flush_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .result_o(result_o), .rd_o(rd_o), .busy_rd_o(busy_rd_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_res(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b);
        logic signed [128:0] ea, eb, p;
        logic signed [63:0]  sa, sb;
        sa = a;
        sb = b;
        ea = {65'b0, a};
        eb = {65'b0, b};
        if (op == OP_MULH || op == OP_MULHSU) ea = {{65{a[63]}}, a};
        if (op == OP_MULH) eb = {{65{b[63]}}, b};
        p = ea * eb;
        case (op)
            OP_MUL:                        return p[63:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  return p[127:64];
            OP_DIV:  return (b == 0) ? ONES : ((a == MIN && b == ONES) ? MIN : 64'(sa / sb));
            OP_DIVU: return (b == 0) ? ONES : a / b;
            OP_REM:  return (b == 0) ? a : ((a == MIN && b == ONES) ? 64'd0 : 64'(sa % sb));
            OP_REMU: return (b == 0) ? a : a % b;
            default: return 64'd0;
        endcase
    endfunction

    function automatic int exp_lat(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b);
        if (op[7:4] != 0)
            return (b == 0 || ((op == OP_DIV || op == OP_REM) && a == MIN && b == ONES)) ? 1 : 65;
`ifdef YSYX_23060251_MUL_FAST_EN
        return 1;
`else
        return 65;
`endif
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return ONES;
            2:       return MIN;
            3:       return 64'($urandom_range(0, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Offer one operation; returns just after the accepting edge.
    task automatic start_op(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
        @(negedge clk);
        chk("idle_ready", 64'(in_ready_o), 64'd1);
        in_valid_i = 1'b1;
        op_i = op;
        src1_i = a;
        src2_i = b;
        rd_i = rd;
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        op_i = '0;
    endtask

    task automatic run_op(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd, input int hold);
        int          cyc;
        bit          rdy_seen;
        logic [63:0] exp_r;
        exp_r = ref_res(op, a, b);
        start_op(op, a, b, rd);
        cyc = 1;
        rdy_seen = 1'b0;
        while (!out_valid_o && cyc < 200) begin
            if (in_ready_o) rdy_seen = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("latency", 64'(cyc), 64'(exp_lat(op, a, b)));
        chk("ready_low", 64'(rdy_seen), 64'd0);
        chk("result", result_o, exp_r);
        chk("rd", 64'(rd_o), 64'(rd));
        chk("busy_rd", 64'(busy_rd_o), 64'(rd));
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            chk("hold_valid", 64'(out_valid_o), 64'd1);
            chk("hold_result", result_o, exp_r);
            chk("hold_rd", 64'(rd_o), 64'(rd));
        end
        out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        out_ready_i = 1'b0;
        chk("handoff_valid", 64'(out_valid_o), 64'd0);
        chk("handoff_ready", 64'(in_ready_o), 64'd1);
        chk("handoff_busy", 64'(busy_rd_o), 64'd0);
    endtask

    initial begin
        logic [7:0] one_hot;
        bit         seen;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid_o), 64'd0);
        chk("rst_result", result_o, 64'd0);
        chk("rst_rd", 64'(rd_o), 64'd0);
        chk("rst_busy", 64'(busy_rd_o), 64'd0);
        chk("rst_ready", 64'(in_ready_o), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // op_i == 0 with in_valid_i must not transfer
        @(negedge clk);
        in_valid_i = 1'b1;
        op_i = 8'h00;
        rd_i = 5'd7;
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        chk("noop_ready", 64'(in_ready_o), 64'd1);
        chk("noop_busy", 64'(busy_rd_o), 64'd0);

        run_op(OP_MUL,    64'd7, -64'sd3, 5'd1, 0);
        run_op(OP_MULHU,  ONES, 64'd2, 5'd2, 0);
        run_op(OP_MULH,   ONES, ONES, 5'd3, 0);
        run_op(OP_MULHSU, ONES, 64'd2, 5'd4, 0);
        run_op(OP_DIV,    -64'sd20, 64'd3, 5'd5, 0);
        run_op(OP_REM,    -64'sd20, 64'd3, 5'd6, 0);
        run_op(OP_DIVU,   64'd20, 64'd3, 5'd7, 0);
        run_op(OP_REMU,   64'd20, 64'd3, 5'd8, 0);
        run_op(OP_DIVU,   64'h1234_5678, 64'd0, 5'd9, 0);
        run_op(OP_REM,    64'd5, 64'd0, 5'd10, 0);
        run_op(OP_DIV,    MIN, ONES, 5'd11, 0);
        run_op(OP_REM,    MIN, ONES, 5'd12, 0);
        run_op(OP_DIV,    64'd100, 64'd7, 5'd13, 10);
        run_op(OP_MUL,    64'd9, 64'd9, 5'd0, 0);

        // flush during a divide: back to IDLE, no result ever delivered
        start_op(OP_DIV, 64'd1000, 64'd7, 5'd14);
        repeat (29) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        chk("flush_ready", 64'(in_ready_o), 64'd1);
        chk("flush_busy", 64'(busy_rd_o), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (out_valid_o) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("flush_no_valid", 64'(seen), 64'd0);

        // flush in DONE beats a simultaneous handoff
        start_op(OP_DIVU, 64'd3, 64'd0, 5'd15);
        flush_i = 1'b1;
        out_ready_i = 1'b1;
        #1;
        chk("flush_done_valid", 64'(out_valid_o), 64'd0);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        out_ready_i = 1'b0;
        chk("flush_done_idle", 64'(in_ready_o), 64'd1);

        // flush beats a simultaneous accept in IDLE
        @(negedge clk);
        flush_i = 1'b1;
        in_valid_i = 1'b1;
        op_i = OP_MUL;
        rd_i = 5'd16;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        op_i = '0;
        chk("flush_accept_busy", 64'(busy_rd_o), 64'd0);
        chk("flush_accept_ready", 64'(in_ready_o), 64'd1);

        // reset during a multiply clears outputs immediately
        start_op(OP_MUL, 64'd123, 64'd456, 5'd17);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(out_valid_o), 64'd0);
        chk("midrst_result", result_o, 64'd0);
        chk("midrst_rd", 64'(rd_o), 64'd0);
        chk("midrst_busy", 64'(busy_rd_o), 64'd0);
        chk("midrst_ready", 64'(in_ready_o), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(OP_MULH, -64'sd5, 64'd11, 5'd18, 0);

        one_hot = 8'h01;
        for (int i = 0; i < 40; i++) begin
            run_op(one_hot << 3'($urandom_range(0, 7)), pick(), pick(),
                   5'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0) ? 2 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
